// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the counter-width function.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell: diff = a - b - bin.
// Pure combinational; the serial FSM reuses it every clock.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, d = a - b, LSB first.
// One full_sub cell processes one bit per clock under a small FSM.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             diff;
  logic             bnext;

  full_sub u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (borrow),
    .diff (diff),
    .bout (bnext)
  );

  // New bit enters at the MSB so the LSB-first stream lands in place.
  assign acc_nx = {diff, acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            acc    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc    <= acc_nx;
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= bnext;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            d     <= acc_nx;
            bout  <= bnext;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=3 and WIDTH=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start3;
  logic [2:0] a3, b3, d3;
  logic       busy3, done3, bout3;

  logic       start8;
  logic [7:0] a8, b8, d8;
  logic       busy8, done8, bout8;

  int n_assert;
  int n_fail;

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start3),
    .a     (a3),
    .b     (b3),
    .busy  (busy3),
    .done  (done3),
    .d     (d3),
    .bout  (bout3)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .d     (d8),
    .bout  (bout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic op3(input logic [2:0] ai, input logic [2:0] bi,
                     input logic [2:0] ed, input logic eb,
                     input string tag);
    int k;
    int bc;
    a3 = ai;
    b3 = bi;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    k = 1;
    bc = 0;
    while (!done3 && k < 20) begin
      if (busy3) bc++;
      @(negedge clk);
      k++;
    end
    if (busy3) bc++;
    chk({tag, ".latency"}, k, 4);
    chk({tag, ".busy_cycles"}, bc, 4);
    chk({tag, ".d"}, int'(d3), int'(ed));
    chk({tag, ".bout"}, int'(bout3), int'(eb));
    @(negedge clk);
    chk({tag, ".done_low"}, int'(done3), 0);
    chk({tag, ".idle"}, int'(busy3), 0);
  endtask

  task automatic op8(input logic [7:0] ai, input logic [7:0] bi,
                     input logic [7:0] ed, input logic eb,
                     input string tag);
    int k;
    a8 = ai;
    b8 = bi;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 1;
    while (!done8 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, k, 9);
    chk({tag, ".d"}, int'(d8), int'(ed));
    chk({tag, ".bout"}, int'(bout8), int'(eb));
    @(negedge clk);
  endtask

  initial begin
    int k;
    int pulses;
    int first_k;
    int second_k;
    int first_d;
    int first_b;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rd;
    logic [2:0] ea;
    logic [2:0] eb3;
    logic [2:0] ed3;

    n_assert = 0;
    n_fail = 0;
    start3 = 1'b0;
    start8 = 1'b0;
    a3 = '0;
    b3 = '0;
    a8 = '0;
    b8 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset.busy", int'(busy3), 0);
    chk("reset.done", int'(done3), 0);
    chk("reset.d", int'(d3), 0);
    chk("reset.bout", int'(bout3), 0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done3 || busy3) pulses++;
    end
    chk("idle.no_activity", pulses, 0);

    op3(3'd3, 3'd2, 3'd1, 1'b0, "basic_3_2");
    op3(3'd3, 3'd4, 3'd7, 1'b1, "uflow_3_4");
    op3(3'd0, 3'd1, 3'd7, 1'b1, "uflow_0_1");
    op3(3'd5, 3'd5, 3'd0, 1'b0, "equal_5_5");

    // start held high; operands change during the first run
    a3 = 3'd4;
    b3 = 3'd3;
    start3 = 1'b1;
    @(negedge clk);
    a3 = 3'd1;
    b3 = 3'd2;
    k = 1;
    pulses = 0;
    first_k = 0;
    second_k = 0;
    first_d = -1;
    first_b = -1;
    while (k <= 12) begin
      if (done3) begin
        pulses++;
        if (first_k == 0) begin
          first_k = k;
          first_d = int'(d3);
          first_b = int'(bout3);
        end else begin
          second_k = k;
          start3 = 1'b0;
        end
      end
      @(negedge clk);
      k++;
    end
    start3 = 1'b0;
    chk("b2b.first_done", first_k, 4);
    chk("b2b.first_d", first_d, 1);
    chk("b2b.first_bout", first_b, 0);
    chk("b2b.second_done", second_k, 9);
    chk("b2b.second_d", int'(d3), 7);
    chk("b2b.second_bout", int'(bout3), 1);
    chk("b2b.pulses", pulses, 2);

    // abort during the second run cycle
    a3 = 3'd6;
    b3 = 3'd1;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy", int'(busy3), 0);
    chk("abort.done", int'(done3), 0);
    chk("abort.d", int'(d3), 0);
    chk("abort.bout", int'(bout3), 0);
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done3) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done3) pulses++;
    end
    chk("abort.no_done", pulses, 0);
    op3(3'd6, 3'd1, 3'd5, 1'b0, "after_abort");

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        ea = 3'(i);
        eb3 = 3'(j);
        ed3 = 3'((i - j + 8) % 8);
        op3(ea, eb3, ed3, (i < j), $sformatf("exh_%0d_%0d", i, j));
      end
    end

    op8(8'h00, 8'h01, 8'hFF, 1'b1, "w8_00_01");
    op8(8'hA5, 8'h5A, 8'h4B, 1'b0, "w8_a5_5a");
    op8(8'h80, 8'h80, 8'h00, 1'b0, "w8_80_80");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rd = 8'((int'(ra) - int'(rb) + 256) % 256);
      op8(ra, rb, rd, (ra < rb), $sformatf("w8_rand_%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: computes d = a - b, LSB first, one bit per clock, with a start/busy/done handshake.
- Sequential counterpart (inverse operation) of the combinational ripple adder.
- Used as the area-minimal arithmetic element in the getting-started datapath examples.
- A WIDTH-bit subtraction takes WIDTH clocks through one 1-bit full-subtractor cell.

Parameters:
- WIDTH, 3, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the edge that accepts start.
- b  input  WIDTH  subtrahend; sampled on the edge that accepts start.
- busy  output  1  high in RUN and DONE; start is ignored while high.
- done  output  1  one-cycle pulse; d and bout are valid from this cycle on.
- d  output  WIDTH  difference (a - b) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b (unsigned).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, d=0, bout=0; internal shift registers, borrow and counter cleared.
- Reset asserted mid-operation aborts the operation. No done is produced. The old result is discarded (d=0).
- States:
  - IDLE: busy=0. On an edge with start=1: latch a into sa and b into sb, clear borrow and result shifter, cnt=0, go to RUN. With start=0, remain in IDLE.
  - RUN: busy=1. Each edge processes bit 0 of sa/sb via full_sub with the borrow register:
    - diff = a0 ^ b0 ^ bin
    - bnext = (~a0 & b0) | (~(a0 ^ b0) & bin)
    - diff shifts into the result shifter MSB; sa and sb shift right; borrow <= bnext; cnt <= cnt+1.
    - On the edge where cnt = WIDTH-1 (the WIDTH-th bit): d <= final shifter contents (including this bit), bout <= bnext, done <= 1, go to DONE.
  - DONE: busy=1, done=1 for exactly this cycle. Next edge: done <= 0, go to IDLE.
- Latency: start accepted at edge N → done high during the cycle after edge N+WIDTH → IDLE after edge N+WIDTH+1. A new start can be accepted at edge N+WIDTH+2 at the earliest. Throughput is one operation per WIDTH+2 clocks.
- d and bout are updated only on entry to DONE. They hold their value through IDLE and through the next RUN until the next DONE.
- start while busy=1 is ignored: no queueing and no effect on the running operation.
- Changes to a and b after acceptance have no effect.
- Wrap-around: the result is modulo 2^WIDTH; bout is the sole underflow indicator. No signed overflow output.
- cnt width: clog2(WIDTH) bits, computed in the package function.

Decomposition:
- Shared package serial_arith_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - function clog2 for cnt width.
- Sub-module full_sub: combinational 1-bit full subtractor, ports a, b, bin → diff, bout. Instantiated once.
- FSM, counter and shifters are kept in serial_subtractor.

Test Plan (WIDTH=3 unless stated):
- Reset then idle: rst_n low 2 cycles, start=0 → busy=0, done=0, d=0, bout=0; no done pulse for 10 cycles.
- Basic subtraction: a=3, b=2, start pulse → done exactly 4 edges after acceptance (cycle after edge N+3), d=1, bout=0; busy high 4 cycles.
- Underflow: a=3, b=4 → d=7, bout=1. Also a=0, b=1 → d=7, bout=1. Also a=5, b=5 → d=0, bout=0.
- Back-to-back ops and ignored start: hold start=1 continuously with a=4, b=3 → d=1, bout=0. Change a and b to 1, 2 during RUN → current result unaffected. Next operation accepted only at edge N+5 → d=7, bout=1. Exactly one done pulse per operation.
- Reset mid-operation: assert rst_n low during the second RUN cycle of a=6, b=1 → outputs 0 immediately (asynchronously, before the next edge), no done. After release, a=6, b=1 → d=5, bout=0.
- Exhaustive and width check: for WIDTH=3, all 64 (a,b) pairs compared against a reference model (d, bout). Repeat a random 1000-pair sweep at WIDTH=8 (e.g. 0x00-0x01 → 0xFF, bout=1).
